// File: rtl/hdb3_tx_ctrl.sv
// Transmit sequencer for the HDB3 encoder chain: accepts bytes over valid/ready,
// serializes them MSB-first with a one-cycle bit strobe, and drains the V/B window with zero bits.
`timescale 1ns/1ps
module hdb3_tx_ctrl #(
  parameter int CLK_DIV    = 4,
  parameter int FLUSH_BITS = 4,
  parameter int DIV_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       bit_out,
  output logic       bit_en,
  output logic       enc_clr,
  output logic       busy,
  output logic       underrun,
  output logic       frame_done
);

  localparam int BIT_MAX = (FLUSH_BITS > 8) ? FLUSH_BITS : 8;
  localparam int CNT_W   = $clog2(BIT_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'((FLUSH_BITS > 0) ? FLUSH_BITS - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_NEXT,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             last_q, last_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             first_next_q, first_next_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    last_d       = last_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    first_next_d = first_next_q;
    tx_ready     = 1'b0;
    bit_out      = 1'b0;
    bit_en       = 1'b0;
    enc_clr      = 1'b0;
    underrun     = 1'b0;
    frame_done   = 1'b0;
    busy         = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          shreg_d = tx_data;
          last_d  = tx_last;
          state_d = S_START;
        end
      end

      S_START: begin
        enc_clr   = 1'b1;
        div_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = S_SHIFT;
      end

      S_SHIFT: begin
        bit_out = shreg_q[7];
        if (div_cnt_q == DIV_LAST) begin
          bit_en    = 1'b1;
          shreg_d   = {shreg_q[6:0], 1'b0};
          div_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            if (!last_q) begin
              first_next_d = 1'b1;
              state_d      = S_NEXT;
            end else if (FLUSH_BITS == 0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_FLUSH;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      // Waiting here keeps encoder state: a late byte continues the same frame.
      S_NEXT: begin
        tx_ready     = 1'b1;
        first_next_d = 1'b0;
        if (tx_valid) begin
          shreg_d   = tx_data;
          last_d    = tx_last;
          div_cnt_d = '0;
          state_d   = S_SHIFT;
        end else if (first_next_q) begin
          underrun = 1'b1;
        end
      end

      S_FLUSH: begin
        if (div_cnt_q == DIV_LAST) begin
          bit_en    = 1'b1;
          div_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == FLUSH_LAST) begin
            bit_cnt_d = '0;
            state_d   = S_DONE;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      last_q       <= 1'b0;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      first_next_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      last_q       <= last_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      first_next_q <= first_next_d;
    end
  end

endmodule

// File: doc/hdb3_tx_ctrl.md
Name: hdb3_tx_ctrl

Overview:
- Transmit sequencer in front of the HDB3 encoder chain (V insertion, B insertion, polarity stage).
- Accepts bytes from a source over a valid/ready handshake and serializes them MSB-first at a programmable bit rate.
- Gives the encoder a bit value plus a one-cycle bit strobe, clears encoder state at frame start, and appends zero bits at frame end so the 4-bit V/B detection window drains.

Parameters:
- CLK_DIV, 4: clk cycles per line bit; legal range 1..256.
- FLUSH_BITS, 4: zero bits appended after the last data bit of a frame; 0 is legal.
- DIV_W, 8: width of the bit-period counter; must satisfy 2^DIV_W >= CLK_DIV.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- tx_data  in  8  byte to transmit
- tx_valid  in  1  tx_data valid
- tx_last  in  1  qualifies tx_data as the final byte of the frame; sampled on handshake
- tx_ready  out  1  block can accept a byte this cycle
- bit_out  out  1  current line bit, stable for the whole bit period
- bit_en  out  1  one-cycle strobe; encoder samples bit_out when high
- enc_clr  out  1  one-cycle pulse clearing encoder state (polarity flag, zero counters)
- busy  out  1  frame in progress (any state other than IDLE)
- underrun  out  1  one-cycle pulse when a mid-frame byte was not ready at a byte boundary
- frame_done  out  1  one-cycle pulse after the final flush bit is strobed

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; shift register, div_cnt and bit_cnt = 0; last flag = 0; all outputs 0 except tx_ready=1 (combinational from IDLE). Reset mid-frame aborts the frame: no frame_done, no further bit_en.
- Handshake: a byte is accepted in any cycle where tx_valid && tx_ready. tx_data and tx_last are ignored when no handshake occurs. tx_ready=1 only in IDLE and NEXT.
- States:
  - IDLE: on accept, load shreg=tx_data, last=tx_last, go to START.
  - START: one cycle; enc_clr=1; div_cnt=0; bit_cnt=0; go to SHIFT.
  - SHIFT:
    - div_cnt counts 0..CLK_DIV-1.
    - bit_out = shreg[7].
    - At div_cnt==CLK_DIV-1: bit_en=1; shreg shifts left; bit_cnt increments; div_cnt wraps to 0.
    - On the 8th strobe: go to FLUSH if last=1, otherwise go to NEXT.
  - NEXT:
    - tx_ready=1; bit_en=0; bit_out=0.
    - Accept in the first NEXT cycle: reload shreg and last, go to SHIFT with div_cnt=0. No enc_clr.
    - No byte in the first NEXT cycle: underrun pulses once. The block stays in NEXT until a byte arrives, and the frame continues (encoder state is kept).
  - FLUSH:
    - bit_out=0.
    - FLUSH_BITS strobes with the same CLK_DIV timing.
    - After the last strobe, go to DONE.
    - FLUSH_BITS=0: go to DONE on the cycle after the 8th data strobe.
  - DONE: frame_done=1 for one cycle; go to IDLE.
- Timing:
  - Accept in cycle N: enc_clr in N+1. First bit_en at N+1+CLK_DIV, then every CLK_DIV cycles within a byte.
  - Back-to-back bytes add exactly 1 NEXT cycle between the 8th strobe and the next period start.
- CLK_DIV=1: bit_en is high on every SHIFT/FLUSH cycle; div_cnt stays 0.
- Frames are independent; enc_clr is issued once per frame only.

Test Plan:
- CLK_DIV=4, FLUSH_BITS=4, single byte 0xA5 with tx_last=1 -> enc_clr 1 cycle after accept; 8 bit_en pulses 4 cycles apart with bit_out 1,0,1,0,0,1,0,1; then 4 strobes with bit_out=0; frame_done 1 cycle after the last strobe; busy drops to 0.
- Two bytes 0x00 then 0xFF, tx_valid held high, last on the second -> 16 data strobes with exactly one 1-cycle NEXT gap, a single enc_clr, underrun never asserted.
- Second byte delayed 10 cycles after the first byte ends -> underrun pulses once; bit_en stays low during the wait; frame resumes with no enc_clr; frame_done once at the end.
- CLK_DIV=1, FLUSH_BITS=0, byte 0x81 last -> bit_en high for 8 consecutive cycles with bit_out 1,0,0,0,0,0,0,1; DONE on the following cycle.
- rst_n asserted after the 3rd strobe of a byte -> all outputs 0 and tx_ready=1 immediately (asynchronous); no frame_done; a new byte after release starts a fresh frame with enc_clr.
- tx_valid pulsed while busy in SHIFT/FLUSH -> not accepted (tx_ready=0); output bit sequence unchanged.
